// File: rtl/vx_reset_sequencer.sv
// Reset distributor: hold all active channels for HOLD_CYCLES, then
// release them one by one in ascending index, STAGE_DELAY apart.
module vx_reset_sequencer #(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         soft_req,
  input  logic [N-1:0] soft_mask,
  output logic         soft_ack,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] reset_o
);

  localparam int MAXD =
    (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CW = $clog2(MAXD) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] SOFT_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LD = CW'(STAGE_DELAY - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_REL,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  rst_d;
  logic          busy_d, done_d, ack_d;

  logic [IW-1:0] idx;
  logic [N-1:0]  sel;
  logic          fire;
  logic          last;
  logic          accept;

  // Lowest pending channel is the next one to release.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = IW'(i);
    end
    sel = N'(1) << idx;
  end

  assign fire   = (state_q != S_RUN) && (cnt_q == '0);
  assign last   = (pend_q & ~sel) == '0;
  assign accept = (state_q == S_RUN) && soft_req && (|soft_mask);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_HOLD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HOLD:  if (fire) state_d = last ? S_RUN : S_REL;
      S_REL:   if (fire && last) state_d = S_RUN;
      S_RUN:   if (accept) state_d = S_HOLD;
      default: state_d = S_HOLD;
    endcase
  end

  // Soft start loads HOLD-1: the acceptance edge itself is the first
  // hold cycle, whereas a hard start counts from the first high edge.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (fire) begin
      cnt_d  = STAGE_LD;
      pend_d = pend_q & ~sel;
    end else if (state_q != S_RUN) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (accept) begin
      cnt_d  = SOFT_LD;
      pend_d = soft_mask;
    end
  end

  always_comb begin
    rst_d  = reset_o;
    busy_d = busy;
    done_d = done;
    ack_d  = accept;
    if (fire) begin
      rst_d = reset_o & ~sel;
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
    if (accept) begin
      rst_d  = reset_o | soft_mask;
      busy_d = 1'b1;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= HOLD_LD;
      pend_q   <= '1;
      reset_o  <= '1;
      busy     <= 1'b1;
      done     <= 1'b0;
      soft_ack <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      reset_o  <= rst_d;
      busy     <= busy_d;
      done     <= done_d;
      soft_ack <= ack_d;
    end
  end

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Bench for vx_reset_sequencer: schedule model feeds a scoreboard queue,
// compared each edge against three parameterisations of the DUT.
module tb_vx_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a = 1'b0, req_a = 1'b0;
  logic [3:0] msk_a = '0;
  logic       ack_a, busy_a, done_a;
  logic [3:0] ro_a;

  logic       rn_b = 1'b0, req_b = 1'b0;
  logic [0:0] msk_b = '0;
  logic       ack_b, busy_b, done_b;
  logic [0:0] ro_b;

  logic       rn_c = 1'b0, req_c = 1'b0;
  logic [7:0] msk_c = '0;
  logic       ack_c, busy_c, done_c;
  logic [7:0] ro_c;

  vx_reset_sequencer #(.N(4), .HOLD_CYCLES(16), .STAGE_DELAY(4)) u_a (
    .clk(clk), .reset_n(rn_a), .soft_req(req_a), .soft_mask(msk_a),
    .soft_ack(ack_a), .busy(busy_a), .done(done_a), .reset_o(ro_a));

  vx_reset_sequencer #(.N(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) u_b (
    .clk(clk), .reset_n(rn_b), .soft_req(req_b), .soft_mask(msk_b),
    .soft_ack(ack_b), .busy(busy_b), .done(done_b), .reset_o(ro_b));

  vx_reset_sequencer #(.N(8), .HOLD_CYCLES(16), .STAGE_DELAY(1)) u_c (
    .clk(clk), .reset_n(rn_c), .soft_req(req_c), .soft_mask(msk_c),
    .soft_ack(ack_c), .busy(busy_c), .done(done_c), .reset_o(ro_c));

  typedef struct {
    logic       r;
    logic       q;
    logic [7:0] m;
    int         n;
  } seg_t;

  int         sel = 0;
  int         m_n, m_hold, m_stage;
  int         e = 0;
  logic [7:0] m_rst;
  bit         m_busy, m_done, m_ack, m_hard, m_seq;
  int         m_rel[8];
  int         m_last;

  logic [10:0] sb[$];
  logic [10:0] x;
  int cmps = 0;
  int errs = 0;

  function automatic seg_t mk(logic r, logic q, logic [7:0] m, int n);
    seg_t s;
    s.r = r; s.q = q; s.m = m; s.n = n;
    return s;
  endfunction

  function automatic logic [7:0] ones();
    return 8'hFF >> (8 - m_n);
  endfunction

  function automatic logic [10:0] got();
    case (sel)
      0:       return {4'b0, ro_a, busy_a, done_a, ack_a};
      1:       return {7'b0, ro_b, busy_b, done_b, ack_b};
      default: return {ro_c, busy_c, done_c, ack_c};
    endcase
  endfunction

  task automatic set_dut(int s, int n, int h, int st);
    sel = s; m_n = n; m_hold = h; m_stage = st;
  endtask

  task automatic start_seq(int t0, logic [7:0] m);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < m_n && m[i]) begin
        m_rel[i] = t0 + m_hold + k * m_stage;
        m_last = m_rel[i];
        k++;
      end else begin
        m_rel[i] = -1;
      end
    end
  endtask

  // Expected outputs after the coming edge, from the release schedule.
  task automatic model_edge(logic r, logic q, logic [7:0] m);
    logic [7:0] mm;
    mm = m & ones();
    e++;
    m_ack = 0;
    if (!r) begin
      m_rst = ones(); m_busy = 1; m_done = 0;
      m_hard = 1; m_seq = 0;
    end else if (m_hard) begin
      m_hard = 0; m_seq = 1;
      start_seq(e, ones());
    end else if (m_seq) begin
      for (int i = 0; i < m_n; i++)
        if (m_rel[i] == e) m_rst[i] = 1'b0;
      if (e == m_last) begin
        m_seq = 0; m_busy = 0; m_done = 1;
      end
    end else if (q && mm != '0) begin
      start_seq(e, mm);
      m_rst = m_rst | mm;
      m_busy = 1; m_done = 0; m_ack = 1; m_seq = 1;
    end
    sb.push_back({m_rst, m_busy, m_done, m_ack});
  endtask

  task automatic drive(seg_t s);
    case (sel)
      0: begin rn_a = s.r; req_a = s.q; msk_a = s.m[3:0]; end
      1: begin rn_b = s.r; req_b = s.q; msk_b = s.m[0:0]; end
      default: begin rn_c = s.r; req_c = s.q; msk_c = s.m; end
    endcase
    model_edge(s.r, s.q, s.m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    seg_t segs[$];
    set_dut(0, 4, 16, 4);
    segs = {mk(0, 0, 0, 3), mk(1, 0, 0, 32)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL reset e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_soft();
    seg_t segs[$];
    segs = {mk(1, 1, 8'hA, 1), mk(1, 0, 0, 24)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL soft e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_mask_zero();
    seg_t segs[$];
    segs = {mk(1, 1, 0, 4), mk(1, 0, 8'hF, 2)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL mask_zero e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_busy_ignore();
    seg_t segs[$];
    segs = {mk(1, 1, 8'hA, 1), mk(1, 1, 8'h5, 24), mk(1, 0, 0, 24)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL busy_ignore e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_preempt();
    seg_t segs[$];
    segs = {mk(1, 1, 8'hA, 1), mk(1, 0, 0, 17),
            mk(0, 0, 0, 1), mk(1, 0, 0, 32)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL preempt e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_n1();
    seg_t segs[$];
    set_dut(1, 1, 1, 1);
    segs = {mk(0, 0, 0, 2), mk(1, 0, 0, 3),
            mk(1, 1, 8'h1, 1), mk(1, 0, 0, 3)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL n1 e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  task automatic test_back_to_back();
    seg_t segs[$];
    set_dut(2, 8, 16, 1);
    segs = {mk(0, 0, 0, 2), mk(1, 0, 0, 26),
            mk(1, 1, 8'h96, 1), mk(1, 0, 0, 22)};
    foreach (segs[i])
      for (int c = 0; c < segs[i].n; c++) begin
        drive(segs[i]);
        x = sb.pop_front();
        cmps++;
        if (got() !== x) begin
          errs++;
          $display("FAIL n8_b2b e%0d got %b want %b", e, got(), x);
        end
      end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_soft();
    test_mask_zero();
    test_busy_ignore();
    test_preempt();
    test_n1();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
